// File: rtl/character_pkg.sv
// Shared motion state type and default physics constants for the character controller.
package character_pkg;

    typedef enum logic [1:0] {GROUND, JUMP, FALL, CLIMB} motion_state_t;

    localparam int DEF_POS_W    = 12;
    localparam int DEF_STEP_DIV = 400000;
    localparam int DEF_GRAV_DIV = 800000;
    localparam int DEF_JUMP_V0  = 6;
    localparam int DEF_JUMP_H   = 40;
    localparam int DEF_VMAX     = 8;
    localparam int DEF_CHAR_W   = 48;
    localparam int DEF_SCREEN_W = 1024;

endpackage

// File: rtl/tick_div.sv
// Free-running divider: one-cycle tick every DIV clocks, counter wraps to 0.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) cnt <= '0;
        else             cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/char_motion.sv
// Character walk/jump/fall controller; ladder climbing is built only when
// CHAR_MOTION_LADDER_EN is defined.
module char_motion
    import character_pkg::*;
#(
    parameter int POS_W    = DEF_POS_W,
    parameter int STEP_DIV = DEF_STEP_DIV,
    parameter int GRAV_DIV = DEF_GRAV_DIV,
    parameter int JUMP_V0  = DEF_JUMP_V0,
    parameter int JUMP_H   = DEF_JUMP_H,
    parameter int VMAX     = DEF_VMAX,
    parameter int CHAR_W   = DEF_CHAR_W,
    parameter int X_INIT   = 1,
    parameter int Y_INIT   = 0,
    parameter int SCREEN_W = DEF_SCREEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic             jump,
    input  logic             up,
    input  logic             down,
    input  logic             enable,
    input  logic             on_ladder,
    input  logic [POS_W-1:0] floor_y,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             airborne,
    output logic             climbing
);
    motion_state_t    state, state_nx;
    logic [POS_W-1:0] xpos_nx, ypos_nx, vel, vel_nx, top, top_nx, vel_up;
    logic [POS_W:0]   x_right, y_sum;
    logic             h_tick, v_tick;

    tick_div #(.DIV(STEP_DIV)) u_h_div (.clk(clk), .rst(rst), .tick(h_tick));
    tick_div #(.DIV(GRAV_DIV)) u_v_div (.clk(clk), .rst(rst), .tick(v_tick));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FALL;
            xpos  <= POS_W'(X_INIT);
            ypos  <= POS_W'(Y_INIT);
            vel   <= '0;
            top   <= '0;
        end else begin
            state <= state_nx;
            xpos  <= xpos_nx;
            ypos  <= ypos_nx;
            vel   <= vel_nx;
            top   <= top_nx;
        end
    end

    always_comb begin
        state_nx = state;
        xpos_nx  = xpos;
        ypos_nx  = ypos;
        vel_nx   = vel;
        top_nx   = top;
        x_right  = {1'b0, xpos} + (POS_W+1)'(CHAR_W);
        vel_up   = (vel >= POS_W'(VMAX)) ? POS_W'(VMAX) : vel + POS_W'(1);
        y_sum    = {1'b0, ypos} + {1'b0, vel_up};

        // Horizontal steering is independent of the vertical state, except on a ladder.
        if (h_tick && enable && state != CLIMB) begin
            if (left && !right && xpos > POS_W'(1))
                xpos_nx = xpos - POS_W'(1);
            else if (right && !left && x_right < (POS_W+1)'(SCREEN_W))
                xpos_nx = xpos + POS_W'(1);
        end

        case (state)
            GROUND: begin
                if (ypos < floor_y) begin
                    state_nx = FALL;
                    vel_nx   = '0;
                end else if (floor_y < ypos) begin
                    ypos_nx = floor_y;
                end else if (jump && enable) begin
                    state_nx = JUMP;
                    vel_nx   = POS_W'(JUMP_V0);
                    top_nx   = (ypos > POS_W'(JUMP_H)) ? ypos - POS_W'(JUMP_H) : '0;
                end
`ifdef CHAR_MOTION_LADDER_EN
                else if (on_ladder && enable && (up || down)) begin
                    state_nx = CLIMB;
                end
`endif
            end
            JUMP: begin
                // ypos never drops below top while rising, so ypos - top cannot wrap.
                if (v_tick) begin
                    if ((ypos - top) <= vel) begin
                        ypos_nx  = top;
                        state_nx = FALL;
                        vel_nx   = '0;
                    end else begin
                        ypos_nx = ypos - vel;
                        vel_nx  = (vel > POS_W'(1)) ? vel - POS_W'(1) : POS_W'(1);
                    end
                end
            end
            FALL: begin
                if (v_tick) begin
                    vel_nx = vel_up;
                    if (y_sum >= {1'b0, floor_y}) begin
                        ypos_nx  = floor_y;
                        state_nx = GROUND;
                        vel_nx   = '0;
                    end else begin
                        ypos_nx = y_sum[POS_W-1:0];
                    end
                end
            end
`ifdef CHAR_MOTION_LADDER_EN
            CLIMB: begin
                if (!on_ladder) begin
                    state_nx = (ypos < floor_y) ? FALL : GROUND;
                    vel_nx   = '0;
                end else if (h_tick && enable) begin
                    if (up && !down) begin
                        if (ypos != '0) ypos_nx = ypos - POS_W'(1);
                    end else if (down && !up) begin
                        if ({1'b0, ypos} + (POS_W+1)'(1) >= {1'b0, floor_y}) begin
                            ypos_nx  = floor_y;
                            state_nx = GROUND;
                        end else begin
                            ypos_nx = ypos + POS_W'(1);
                        end
                    end
                end
            end
`endif
            default: state_nx = FALL;
        endcase
    end

    assign airborne = (state == JUMP) || (state == FALL);

`ifdef CHAR_MOTION_LADDER_EN
    assign climbing = (state == CLIMB);
`else
    logic unused_ladder;
    assign unused_ladder = ^{up, down, on_ladder};
    assign climbing      = 1'b0;
`endif

endmodule

// File: tb/tb_char_motion.sv
// Randomized and directed check of char_motion against a behavioural model.
module tb_char_motion;
    localparam int STEP_DIV = 4, GRAV_DIV = 4, JUMP_V0 = 4, JUMP_H = 10, VMAX = 8;
    localparam int CHAR_W = 48, SCREEN_W = 1024, X_EDGE = SCREEN_W - CHAR_W;
    localparam int M_GND = 0, M_JUMP = 1, M_FALL = 2, M_CLIMB = 3;

    logic        clk = 0, rst = 1;
    logic        left = 0, right = 0, jump = 0, up = 0, down = 0, enable = 0, on_ladder = 0;
    logic [11:0] floor_y = 100;
    logic [11:0] xpos, ypos;
    logic        airborne, climbing;

    int n_vec = 0, n_err = 0;
    int m_mode, m_x, m_y, m_v, m_top, m_cyc;
    int seen[$];

    char_motion #(
        .POS_W(12), .STEP_DIV(STEP_DIV), .GRAV_DIV(GRAV_DIV), .JUMP_V0(JUMP_V0),
        .JUMP_H(JUMP_H), .VMAX(VMAX), .CHAR_W(CHAR_W), .X_INIT(1), .Y_INIT(0),
        .SCREEN_W(SCREEN_W)
    ) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .jump(jump), .up(up),
        .down(down), .enable(enable), .on_ladder(on_ladder), .floor_y(floor_y),
        .xpos(xpos), .ypos(ypos), .airborne(airborne), .climbing(climbing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    // Predicts the position and mode after the coming clock edge from the current inputs.
    task automatic model_step();
        bit h, g;
        int ny, fy;
        fy = int'(floor_y);
        if (rst) begin
            m_mode = M_FALL; m_x = 1; m_y = 0; m_v = 0; m_top = 0; m_cyc = 0;
            return;
        end
        h = (m_cyc % STEP_DIV) == STEP_DIV - 1;
        g = (m_cyc % GRAV_DIV) == GRAV_DIV - 1;
        m_cyc++;
        if (h && enable && m_mode != M_CLIMB) begin
            if (left && !right && m_x > 1) m_x--;
            else if (right && !left && m_x + CHAR_W < SCREEN_W) m_x++;
        end
        case (m_mode)
            M_GND: begin
                if (m_y < fy) begin m_mode = M_FALL; m_v = 0; end
                else if (m_y > fy) m_y = fy;
                else if (jump && enable) begin
                    m_mode = M_JUMP; m_v = JUMP_V0; m_top = imax(m_y - JUMP_H, 0);
                end
`ifdef CHAR_MOTION_LADDER_EN
                else if (on_ladder && enable && (up || down)) m_mode = M_CLIMB;
`endif
            end
            M_JUMP: if (g) begin
                ny = m_y - m_v;
                if (ny <= m_top) begin m_y = m_top; m_mode = M_FALL; m_v = 0; end
                else begin m_y = ny; m_v = imax(m_v - 1, 1); end
            end
            M_FALL: if (g) begin
                m_v = imin(m_v + 1, VMAX);
                m_y = imin(m_y + m_v, fy);
                if (m_y == fy) begin m_mode = M_GND; m_v = 0; end
            end
            default: begin
                if (!on_ladder) begin m_mode = (m_y < fy) ? M_FALL : M_GND; m_v = 0; end
                else if (h && enable) begin
                    if (up && !down) m_y = imax(m_y - 1, 0);
                    else if (down && !up) begin
                        if (m_y + 1 >= fy) begin m_y = fy; m_mode = M_GND; end
                        else m_y++;
                    end
                end
            end
        endcase
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        chk("x", int'(xpos), m_x);
        chk("y", int'(ypos), m_y);
        chk("airborne", int'(airborne), int'(m_mode == M_JUMP || m_mode == M_FALL));
        chk("climbing", int'(climbing), int'(m_mode == M_CLIMB));
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 400 && airborne; i++) step();
        chk(tag, int'(airborne), 0);
    endtask

    // Records each new ypos value until the character is back on the ground.
    task automatic collect_flight();
        int prev;
        seen.delete();
        prev = int'(ypos);
        for (int i = 0; i < 400; i++) begin
            step();
            if (int'(ypos) != prev) seen.push_back(int'(ypos));
            prev = int'(ypos);
            if (!airborne) break;
        end
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    initial begin
        int exp_j[8]  = '{96, 93, 91, 90, 91, 93, 96, 100};
        int exp_f[10] = '{101, 103, 106, 110, 115, 121, 128, 136, 144, 150};

        do_reset();
        chk("rst_x", int'(xpos), 1);
        chk("rst_y", int'(ypos), 0);
        chk("rst_air", int'(airborne), 1);
        enable = 1;
        settle("land_initial");
        chk("land_y", int'(ypos), 100);

        right = 1;
        repeat (40) step();
        chk("walk_x", int'(xpos), 11);
        for (int i = 0; i < 4200 && int'(xpos) != X_EDGE; i++) step();
        repeat (20) step();
        chk("edge_x", int'(xpos), X_EDGE);
        left = 1;
        repeat (20) step();
        chk("both_x", int'(xpos), X_EDGE);
        right = 0; enable = 0;
        repeat (20) step();
        chk("disabled_x", int'(xpos), X_EDGE);
        enable = 1;

        do_reset();
        settle("land_after_rst");
        repeat (20) step();
        chk("left_min_x", int'(xpos), 1);
        left = 0;

        jump = 1; step(); jump = 0;
        chk("jump_air", int'(airborne), 1);
        collect_flight();
        chk("jump_len", seen.size(), 8);
        for (int i = 0; i < 8; i++) chk("jump_y", (i < seen.size()) ? seen[i] : -1, exp_j[i]);
        chk("jump_land", int'(airborne), 0);

        floor_y = 150; step();
        chk("fall_start", int'(airborne), 1);
        collect_flight();
        chk("fall_len", seen.size(), 10);
        for (int i = 0; i < 10; i++) chk("fall_y", (i < seen.size()) ? seen[i] : -1, exp_f[i]);
        chk("fall_land", int'(airborne), 0);

        jump = 1; step(); jump = 0;
        repeat (6) step();
        rst = 1; step(); rst = 0;
        chk("midjump_rst_x", int'(xpos), 1);
        chk("midjump_rst_y", int'(ypos), 0);
        chk("midjump_rst_air", int'(airborne), 1);

`ifdef CHAR_MOTION_LADDER_EN
        floor_y = 100;
        settle("ladder_pre_land");
        on_ladder = 1; up = 1;
        for (int i = 0; i < 200 && int'(ypos) != 80; i++) step();
        chk("ladder_top_y", int'(ypos), 80);
        chk("ladder_climbing", int'(climbing), 1);
        on_ladder = 0; up = 0; step();
        chk("ladder_drop_air", int'(airborne), 1);
        settle("ladder_land");
        chk("ladder_land_y", int'(ypos), 100);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            left      = $urandom_range(0, 1);
            right     = $urandom_range(0, 1);
            jump      = ($urandom_range(0, 7) == 0);
            up        = $urandom_range(0, 1);
            down      = $urandom_range(0, 1);
            on_ladder = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 39) == 0) floor_y = 12'($urandom_range(40, 220));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
